// File: rtl/bsr_sched_pkg.sv
// Shared types and constants for the BSR block scheduler.
package bsr_sched_pkg;

  localparam int DEF_N_ROWS = 14;
  localparam int DEF_N_COLS = 14;
  // Cycles for the last activation to leave the array's skewed pipeline.
  localparam int DRAIN_CYC  = DEF_N_ROWS + DEF_N_COLS - 1;

  typedef enum logic [2:0] {
    IDLE, CLEAR, FETCH, LOAD, STREAM, DRAIN, OUTPUT
  } sched_state_e;

  typedef struct packed {
    logic zero;
    logic last;
  } bsr_desc_t;

  function automatic int drain_cycles(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/bsr_block_scheduler_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count up on i_inc, stick at all-ones, clear on rst or i_clr.
  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != '1))
      r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/bsr_block_scheduler.sv
// Walks one output tile's BSR block row through the 14x14 systolic array:
// zero blocks are skipped, non-zero blocks get load / stream / drain.
module bsr_block_scheduler
  import bsr_sched_pkg::*;
#(
  parameter int N_ROWS = 14,
  parameter int N_COLS = 14,
  parameter int DATA_W = 8,
  parameter int M_W    = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [M_W-1:0]           cfg_m,
  input  logic                     desc_valid,
  output logic                     desc_ready,
  input  logic                     desc_zero,
  input  logic                     desc_last,
  input  logic                     w_burst_rdy,
  output logic                     w_rd_en,
  input  logic [N_COLS*DATA_W-1:0] w_row,
  input  logic                     act_valid,
  output logic                     act_ready,
  input  logic [N_ROWS*DATA_W-1:0] act_data,
  output logic                     arr_block_valid,
  output logic                     arr_load_weight,
  output logic                     arr_clr,
  output logic [N_ROWS*DATA_W-1:0] arr_a_flat,
  output logic [N_COLS*DATA_W-1:0] arr_b_flat,
  output logic                     c_valid,
  input  logic                     c_ready,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         blk_computed,
  output logic [CNT_W-1:0]         blk_skipped
);

  localparam int DRAIN_LEN = drain_cycles(N_ROWS, N_COLS);
  localparam int LD_W      = $clog2(DRAIN_LEN);
  localparam int SEQ_W     = (M_W > LD_W) ? M_W : LD_W;

  sched_state_e     r_state, w_next;
  logic [SEQ_W-1:0] r_seq;     // cycle / beat index within the current phase
  logic [M_W-1:0]   r_mcfg;
  logic             r_last;

  bsr_desc_t w_desc;
  logic      w_start, w_inc_comp, w_inc_skip, w_beat;
  logic      w_load_end, w_drain_end, w_beat_last;

  assign w_desc      = '{zero: desc_zero, last: desc_last};
  assign w_beat      = (r_state == STREAM) && act_valid;
  assign w_load_end  = (r_seq == SEQ_W'(N_ROWS - 1));
  assign w_drain_end = (r_seq == SEQ_W'(DRAIN_LEN - 1));
  assign w_beat_last = (r_seq == (SEQ_W'(r_mcfg) - SEQ_W'(1)));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Phase sequencing, beat target and last-block flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq  <= '0;
      r_mcfg <= '0;
      r_last <= 1'b0;
    end else begin
      if (w_next != r_state)
        r_seq <= '0;
      else if ((r_state == LOAD) || (r_state == DRAIN) || w_beat)
        r_seq <= r_seq + SEQ_W'(1);
      if (w_start)
        r_mcfg <= (cfg_m == '0) ? M_W'(1) : cfg_m;
      if ((r_state == FETCH) && desc_ready && !w_desc.zero)
        r_last <= w_desc.last;
    end
  end

  // Next state and per-state array/handshake controls.
  always_comb begin
    w_next          = r_state;
    desc_ready      = 1'b0;
    w_rd_en         = 1'b0;
    act_ready       = 1'b0;
    arr_block_valid = 1'b0;
    arr_load_weight = 1'b0;
    arr_clr         = 1'b0;
    c_valid         = 1'b0;
    done            = 1'b0;
    w_start         = 1'b0;
    w_inc_comp      = 1'b0;
    w_inc_skip      = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_start = 1'b1;
        w_next  = CLEAR;
      end
      CLEAR: begin
        arr_clr = 1'b1;
        w_next  = FETCH;
      end
      FETCH: if (desc_valid) begin
        if (w_desc.zero) begin
          desc_ready = 1'b1;
          w_inc_skip = 1'b1;
          if (w_desc.last) w_next = OUTPUT;
        end else if (w_burst_rdy) begin
          // The array's row pointer resets if load_weight drops, so the
          // whole block must already be buffered before LOAD starts.
          desc_ready = 1'b1;
          w_next     = LOAD;
        end
      end
      LOAD: begin
        arr_load_weight = 1'b1;
        w_rd_en         = 1'b1;
        if (w_load_end) w_next = STREAM;
      end
      STREAM: begin
        act_ready       = 1'b1;
        arr_block_valid = act_valid;   // empty source freezes the array
        if (act_valid && w_beat_last) begin
          w_next     = DRAIN;
          w_inc_comp = 1'b1;
        end
      end
      DRAIN: begin
        arr_block_valid = 1'b1;
        if (w_drain_end) w_next = r_last ? OUTPUT : FETCH;
      end
      OUTPUT: begin
        c_valid = 1'b1;
        if (c_ready) begin
          arr_clr = 1'b1;
          done    = 1'b1;
          w_next  = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign arr_a_flat = (act_valid && act_ready) ? act_data : '0;
  assign arr_b_flat = (r_state == LOAD) ? w_row : '0;
  assign busy       = (r_state != IDLE);

  sat_counter #(.W(CNT_W)) u_cnt_comp (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_start),
    .i_inc (w_inc_comp),
    .o_cnt (blk_computed)
  );

  sat_counter #(.W(CNT_W)) u_cnt_skip (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_start),
    .i_inc (w_inc_skip),
    .o_cnt (blk_skipped)
  );

endmodule

// File: tb/tb_bsr_block_scheduler.sv
// Directed bench for bsr_block_scheduler: a work-queue model predicts every
// output each cycle, and per-tile event totals are pinned to hand counts.
module tb_bsr_block_scheduler;

  localparam int NR = 14, NC = 14, DW = 8, MW = 8, CW = 16;
  localparam int AW = NR*DW, BW = NC*DW, DRN = NR+NC-1;
  localparam int T_CLR = 1, T_FETCH = 2, T_LOAD = 3, T_BEAT = 4, T_DRAIN = 5, T_OUT = 6;

  logic          clk = 1'b0;
  logic          rst, start, w_burst_rdy, c_ready;
  logic [MW-1:0] cfg_m;
  logic          desc_valid, desc_ready, desc_zero, desc_last;
  logic          w_rd_en, act_valid, act_ready;
  logic [BW-1:0] w_row, arr_b_flat;
  logic [AW-1:0] act_data, arr_a_flat;
  logic          arr_block_valid, arr_load_weight, arr_clr, c_valid, busy, done;
  logic [CW-1:0] blk_computed, blk_skipped;

  always #5 clk = ~clk;

  bsr_block_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .cfg_m(cfg_m),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_zero(desc_zero), .desc_last(desc_last),
    .w_burst_rdy(w_burst_rdy), .w_rd_en(w_rd_en), .w_row(w_row),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .arr_block_valid(arr_block_valid), .arr_load_weight(arr_load_weight), .arr_clr(arr_clr),
    .arr_a_flat(arr_a_flat), .arr_b_flat(arr_b_flat),
    .c_valid(c_valid), .c_ready(c_ready), .busy(busy), .done(done),
    .blk_computed(blk_computed), .blk_skipped(blk_skipped)
  );

  // ---------------- sources (descriptor list, weight FIFO, activation FIFO)
  int          dptr = 0, ndesc = 0, ridx = 0, aidx = 0;
  logic [63:0] dz_arr = '0, dl_arr = '0;
  logic [15:0] av_pat = '0;
  int          av_ptr = 0, av_start = 0, av_len = 0;

  function automatic logic [BW-1:0] row_pat(input int k);
    logic [BW-1:0] r;
    for (int c = 0; c < NC; c++) r[c*DW +: DW] = 8'(k*16 + c + 1);
    return r;
  endfunction

  function automatic logic [AW-1:0] act_pat(input int k);
    logic [AW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = 8'((k*3 + i) ^ 160);
    return r;
  endfunction

  assign desc_valid = (dptr < ndesc);
  assign desc_zero  = dz_arr[dptr[5:0]];
  assign desc_last  = dl_arr[dptr[5:0]];
  assign w_row      = row_pat(ridx);
  assign act_data   = act_pat(aidx);
  assign act_valid  = ((av_ptr - av_start) < av_len) ? av_pat[(av_ptr - av_start) & 15] : 1'b1;

  // ---------------- model: queue of pending work items for the tile
  int  sched[$];
  int  beats_left = 0, m_cfg = 1, e_comp = 0, e_skip = 0;
  int  n_vec = 0, n_fail = 0;
  bit  chk_en = 0;

  // sampled each negedge
  logic          s_rst, s_start, s_dv, s_dz, s_dl, s_wb, s_av, s_cr;
  logic [MW-1:0] s_cfgm;
  logic [AW-1:0] s_adata, s_a;
  logic [BW-1:0] s_wrow;
  logic          s_took_w, s_took_a, s_took_d, s_ar, s_done, s_cv, s_busy, s_clr, s_ld, s_bv;
  logic [CW-1:0] s_cc, s_cs;
  int mon_busy = 0, mon_clr = 0, mon_ld = 0, mon_bv = 0, mon_dr = 0, mon_done = 0, mon_beats = 0, mon_cv = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    logic e_dr, e_wr, e_ar, e_bv, e_ld, e_clr, e_cv, e_done;
    logic [AW-1:0] e_a;
    logic [BW-1:0] e_b;
    int tk;
    e_dr = 0; e_wr = 0; e_ar = 0; e_bv = 0; e_ld = 0; e_clr = 0; e_cv = 0; e_done = 0;
    e_a = '0; e_b = '0;
    tk = (sched.size() != 0) ? sched[0] : 0;
    case (tk)
      T_CLR:   e_clr = 1;
      T_FETCH: e_dr = s_dv && (s_dz || s_wb);
      T_LOAD:  begin e_ld = 1; e_wr = 1; e_b = s_wrow; end
      T_BEAT:  begin e_ar = 1; e_bv = s_av; e_a = s_av ? s_adata : '0; end
      T_DRAIN: e_bv = 1;
      T_OUT:   begin e_cv = 1; e_clr = s_cr; e_done = s_cr; end
      default: ;
    endcase
    chk("desc_ready",      128'(desc_ready),      128'(e_dr));
    chk("w_rd_en",         128'(w_rd_en),         128'(e_wr));
    chk("act_ready",       128'(act_ready),       128'(e_ar));
    chk("arr_block_valid", 128'(arr_block_valid), 128'(e_bv));
    chk("arr_load_weight", 128'(arr_load_weight), 128'(e_ld));
    chk("arr_clr",         128'(arr_clr),         128'(e_clr));
    chk("arr_a_flat",      128'(arr_a_flat),      128'(e_a));
    chk("arr_b_flat",      128'(arr_b_flat),      128'(e_b));
    chk("c_valid",         128'(c_valid),         128'(e_cv));
    chk("done",            128'(done),            128'(e_done));
    chk("busy",            128'(busy),            128'(sched.size() != 0));
    chk("blk_computed",    128'(blk_computed),    128'(e_comp));
    chk("blk_skipped",     128'(blk_skipped),     128'(e_skip));
  endtask

  task automatic model_step();
    if (s_rst) begin
      sched.delete(); e_comp = 0; e_skip = 0;
    end else if (sched.size() == 0) begin
      if (s_start) begin
        m_cfg = (s_cfgm == 0) ? 1 : int'(s_cfgm);
        e_comp = 0; e_skip = 0;
        sched.push_back(T_CLR); sched.push_back(T_FETCH);
      end
    end else begin
      case (sched[0])
        T_FETCH: if (s_dv) begin
          if (s_dz) begin
            if (e_skip < 65535) e_skip++;
            if (s_dl) begin void'(sched.pop_front()); sched.push_back(T_OUT); end
          end else if (s_wb) begin
            void'(sched.pop_front());
            for (int i = 0; i < NR; i++) sched.push_back(T_LOAD);
            sched.push_back(T_BEAT);
            for (int i = 0; i < DRN; i++) sched.push_back(T_DRAIN);
            sched.push_back(s_dl ? T_OUT : T_FETCH);
            beats_left = m_cfg;
          end
        end
        T_BEAT: if (s_av) begin
          beats_left--;
          if (beats_left == 0) begin
            void'(sched.pop_front());
            if (e_comp < 65535) e_comp++;
          end
        end
        T_OUT: if (s_cr) void'(sched.pop_front());
        default: void'(sched.pop_front());
      endcase
    end
  endtask

  task automatic tick();
    @(negedge clk);
    s_rst = rst; s_start = start; s_cfgm = cfg_m; s_dv = desc_valid; s_dz = desc_zero;
    s_dl = desc_last; s_wb = w_burst_rdy; s_av = act_valid; s_cr = c_ready;
    s_adata = act_data; s_wrow = w_row;
    s_took_w = w_rd_en; s_took_a = act_valid && act_ready; s_took_d = desc_valid && desc_ready;
    s_ar = act_ready; s_done = done; s_cv = c_valid; s_busy = busy; s_clr = arr_clr;
    s_ld = arr_load_weight; s_bv = arr_block_valid; s_a = arr_a_flat;
    s_cc = blk_computed; s_cs = blk_skipped;
    if (chk_en) check_cycle();
    mon_busy += int'(busy); mon_clr += int'(arr_clr); mon_ld += int'(arr_load_weight);
    mon_bv += int'(arr_block_valid); mon_dr += int'(s_took_d); mon_done += int'(done);
    mon_beats += int'(s_took_a); mon_cv += int'(c_valid);
    @(posedge clk); #1;
    model_step();
    if (s_took_w) ridx++;
    if (s_took_a) aidx++;
    if (s_took_d) dptr++;
    if (s_ar) av_ptr++;
  endtask

  task automatic add_desc(input bit z, input bit l);
    dz_arr[ndesc] = z; dl_arr[ndesc] = l; ndesc++;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    s_done = 0;
    while (!s_done && k < 400) begin tick(); k++; end
    if (!s_done) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic run_tile(input int m);
    cfg_m = MW'(m); start = 1; tick(); start = 0; cfg_m = '0;
  endtask

  int b_busy, b_clr, b_ld, b_bv, b_dr, b_done, b_beats, b_cv;
  task automatic snap();
    b_busy = mon_busy; b_clr = mon_clr; b_ld = mon_ld; b_bv = mon_bv;
    b_dr = mon_dr; b_done = mon_done; b_beats = mon_beats; b_cv = mon_cv;
  endtask

  initial begin
    rst = 1; start = 0; cfg_m = '0; w_burst_rdy = 1; c_ready = 1;
    tick(); tick();
    chk_en = 1;
    tick();
    rst = 0;
    tick();
    chk("reset_busy", 128'(s_busy), 0);
    chk("reset_cnt",  128'({s_cc, s_cs}), 0);

    // one non-zero+last block, m=4
    add_desc(0, 1); snap(); run_tile(4); wait_done("t1");
    chk("t1_busy_cycles", 128'(mon_busy - b_busy), 48);
    chk("t1_load_cycles", 128'(mon_ld - b_ld), 14);
    chk("t1_bv_cycles",   128'(mon_bv - b_bv), 31);
    chk("t1_clr_cycles",  128'(mon_clr - b_clr), 2);
    chk("t1_rows_popped", 128'(ridx), 14);
    chk("t1_computed",    128'(blk_computed), 1);
    tick();

    // zero, zero, nonzero, zero+last with m=2
    add_desc(1, 0); add_desc(1, 0); add_desc(0, 0); add_desc(1, 1);
    snap(); run_tile(2); wait_done("t2");
    chk("t2_busy_cycles", 128'(mon_busy - b_busy), 49);
    chk("t2_desc_taken",  128'(mon_dr - b_dr), 4);
    chk("t2_load_cycles", 128'(mon_ld - b_ld), 14);
    chk("t2_counts",      128'({blk_computed, blk_skipped}), 128'({16'd1, 16'd3}));
    tick();

    // activation stall 1,0,0,1,1 with m=3
    av_start = av_ptr; av_len = 5; av_pat = 16'b11001;
    add_desc(0, 1); snap(); run_tile(3); wait_done("t3");
    chk("t3_busy_cycles", 128'(mon_busy - b_busy), 49);
    chk("t3_bv_cycles",   128'(mon_bv - b_bv), 30);
    chk("t3_beats",       128'(mon_beats - b_beats), 3);
    av_len = 0; tick();

    // weight buffer not ready for 10 FETCH cycles
    w_burst_rdy = 0; add_desc(0, 1); snap(); run_tile(1);
    repeat (11) tick();
    chk("t4_stall_dready", 128'(mon_dr - b_dr), 0);
    chk("t4_stall_load",   128'(mon_ld - b_ld), 0);
    w_burst_rdy = 1; wait_done("t4");
    chk("t4_busy_cycles", 128'(mon_busy - b_busy), 55);
    chk("t4_load_cycles", 128'(mon_ld - b_ld), 14);
    tick();

    // cfg_m=0 acts as 1 beat; output backpressure with ignored starts
    c_ready = 0; add_desc(0, 1); snap(); run_tile(0);
    begin
      int k;
      k = 0; s_cv = 0;
      while (!s_cv && k < 200) begin tick(); k++; end
      if (!s_cv) chk("t5_cvalid_timeout", 0, 1);
    end
    b_cv = mon_cv; b_clr = mon_clr;
    for (int i = 0; i < 20; i++) begin
      start = (i % 5 == 0); cfg_m = 8'd7; tick();
    end
    start = 0; cfg_m = '0;
    chk("t5_cvalid_held", 128'(mon_cv - b_cv), 20);
    chk("t5_clr_low",     128'(mon_clr - b_clr), 0);
    c_ready = 1; wait_done("t5");
    chk("t5_bv_cycles",   128'(mon_bv - b_bv), 28);
    chk("t5_done_count",  128'(mon_done - b_done), 1);
    tick();
    chk("t5_idle_after",  128'(s_busy), 0);

    // first descriptor zero+last
    add_desc(1, 1); snap(); run_tile(2); wait_done("t6");
    chk("t6_busy_cycles", 128'(mon_busy - b_busy), 3);
    chk("t6_counts",      128'({blk_computed, blk_skipped}), 128'({16'd0, 16'd1}));
    chk("t6_load_cycles", 128'(mon_ld - b_ld), 0);
    tick();

    // reset at beat 2 of 4
    add_desc(1, 0); add_desc(0, 1); snap(); run_tile(4);
    begin
      int k;
      k = 0;
      while ((mon_beats - b_beats) < 2 && k < 200) begin tick(); k++; end
      if ((mon_beats - b_beats) < 2) chk("t7_beat_timeout", 0, 1);
    end
    rst = 1; tick(); rst = 0; tick();
    chk("t7_busy",  128'(s_busy), 0);
    chk("t7_arr",   128'({s_clr, s_ld, s_bv, s_ar, s_cv}), 0);
    chk("t7_a",     128'(s_a), 0);
    chk("t7_cnts",  128'({s_cc, s_cs}), 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
